// File: rtl/halflife_decay_ctrl.sv
// halflife_decay_ctrl
// Command-side sequencer that drives a half-life up/down counter through an
// emulated radioactive decay: load an initial population, then issue
// single-cycle decrements, doubling the step interval (saturating) every time
// the population falls to the current half-life mark.
//
// Optional build macro: HALFLIFE_AUTORELOAD_EN
//   defined   -> DONE loops back to LOAD and the run repeats with the captured
//                population and the originally captured interval until
//                abort or rst.
//   undefined -> DONE returns to IDLE.
module halflife_decay_ctrl #(
  parameter int N = 4,
  parameter int P = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] init_val,
  input  logic [P-1:0] period,
  input  logic [N-1:0] count_i,
  output logic         load_o,
  output logic [N-1:0] load_val,
  output logic         down_o,
  output logic         busy_o,
  output logic         halflife_o,
  output logic         done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0] r_pop0;
  logic [N-1:0] r_thresh;
  logic [P-1:0] r_ivl;
  logic [P-1:0] r_tick;
`ifdef HALFLIFE_AUTORELOAD_EN
  // Interval as captured at start, restored on every automatic reload.
  logic [P-1:0] r_ivl0;
`endif

  logic [P-1:0] w_period_eff;
  logic [P:0]   w_ivl_x2;
  logic [P-1:0] w_ivl_sat;
  logic         w_cnt_zero;
  logic         w_cross;
  logic         w_tick_last;

  // A zero period would make WAIT degenerate, so it is promoted to 1.
  assign w_period_eff = (period == '0) ? P'(1) : period;

  // Doubling keeps the carry bit so an overflow saturates to all-ones
  // instead of wrapping to a small interval.
  assign w_ivl_x2  = {r_ivl, 1'b0};
  assign w_ivl_sat = w_ivl_x2[P] ? '1 : w_ivl_x2[P-1:0];

  // Zero is tested first so the final step never also reports a half-life.
  assign w_cnt_zero  = (count_i == '0);
  assign w_cross     = !w_cnt_zero && (count_i <= r_thresh);
  assign w_tick_last = (r_tick == P'(1));

  // State register; rst dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; abort overrides any transition out of a busy state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_cnt_zero) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_tick_last) begin
          w_state_next = S_STEP;
        end
      end
      S_STEP: begin
        w_state_next = S_CHECK;
      end
      S_DONE: begin
`ifdef HALFLIFE_AUTORELOAD_EN
        w_state_next = S_LOAD;
`else
        w_state_next = S_IDLE;
`endif
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end
  end

  // Datapath registers: capture on start, arm the mark on load, and update
  // mark/interval/wait counter at each check. Abort leaves these untouched
  // beyond what the current state would normally do.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop0   <= '0;
      r_thresh <= '0;
      r_ivl    <= '0;
      r_tick   <= '0;
`ifdef HALFLIFE_AUTORELOAD_EN
      r_ivl0   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pop0 <= init_val;
            r_ivl  <= w_period_eff;
`ifdef HALFLIFE_AUTORELOAD_EN
            r_ivl0 <= w_period_eff;
`endif
          end
        end
        S_LOAD: begin
          r_thresh <= r_pop0 >> 1;
`ifdef HALFLIFE_AUTORELOAD_EN
          r_ivl    <= r_ivl0;
`endif
        end
        S_CHECK: begin
          if (!w_cnt_zero) begin
            if (w_cross) begin
              r_thresh <= r_thresh >> 1;
              r_ivl    <= w_ivl_sat;
              r_tick   <= w_ivl_sat;
            end else begin
              r_tick   <= r_ivl;
            end
          end
        end
        S_WAIT: begin
          r_tick <= r_tick - P'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from the registered state; the half-life flag additionally
  // qualifies CHECK with the fed-back count against the current mark.
  always_comb begin
    load_o     = (r_state == S_LOAD);
    down_o     = (r_state == S_STEP);
    busy_o     = (r_state != S_IDLE);
    halflife_o = (r_state == S_CHECK) && w_cross;
    done_o     = (r_state == S_DONE);
    load_val   = r_pop0;
  end

endmodule

// File: tb/tb_halflife_decay_ctrl.sv
// Testbench for halflife_decay_ctrl: two instances (P=16 and P=4), each with a
// behavioural up/down counter attached. Expected command/pulse events are
// computed from the decay rules and queued at start; a negedge monitor pops
// and compares every pulse the DUTs present.
module tb_halflife_decay_ctrl;

  localparam int K_LOAD = 0;
  localparam int K_HL   = 1;
  localparam int K_DOWN = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int cyc;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // dut0: P = 16
  logic        start0, abort0;
  logic [3:0]  init0;
  logic [15:0] per0;
  logic [3:0]  cnt0;
  logic        load0, down0, busy0, hl0, done0;
  logic [3:0]  lval0;

  // dut1: P = 4
  logic        start1, abort1;
  logic [3:0]  init1;
  logic [3:0]  per1;
  logic [3:0]  cnt1;
  logic        load1, down1, busy1, hl1, done1;
  logic [3:0]  lval1;

  halflife_decay_ctrl #(.N(4), .P(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .init_val(init0), .period(per0), .count_i(cnt0),
    .load_o(load0), .load_val(lval0), .down_o(down0), .busy_o(busy0),
    .halflife_o(hl0), .done_o(done0)
  );

  halflife_decay_ctrl #(.N(4), .P(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .init_val(init1), .period(per1), .count_i(cnt1),
    .load_o(load1), .load_val(lval1), .down_o(down1), .busy_o(busy1),
    .halflife_o(hl1), .done_o(done1)
  );

  // Counters under control: load has priority, up input tied low.
  always @(posedge clk) begin
    if (rst) cnt0 <= 4'd0;
    else if (load0) cnt0 <= lval0;
    else if (down0) cnt0 <= cnt0 - 4'd1;
  end
  always @(posedge clk) begin
    if (rst) cnt1 <= 4'd0;
    else if (load1) cnt1 <= lval1;
    else if (down1) cnt1 <= cnt1 - 4'd1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_LOAD:  return "load";
      K_HL:    return "halflife";
      K_DOWN:  return "down";
      default: return "done";
    endcase
  endfunction

  task automatic push(input int d, input int k, input int c);
    evt_t e;
    e.kind = k;
    e.cyc  = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Reference: event schedule of one run, relative to the cycle in which
  // start is presented (load in the next cycle, first check one after).
  task automatic push_model(input int d, input int init, input int per,
                            input int satmax, input int base);
    int pop;
    int thr;
    int ivl;
    int t;
    pop = init;
    thr = init / 2;
    ivl = (per == 0) ? 1 : per;
    t   = 2;
    push(d, K_LOAD, base + 1);
    while (1) begin
      if (pop == 0) begin
        push(d, K_DONE, base + t + 1);
        break;
      end
      if (pop <= thr) begin
        push(d, K_HL, base + t);
        thr = thr / 2;
        ivl = (ivl * 2 > satmax) ? satmax : ivl * 2;
      end
      push(d, K_DOWN, base + t + ivl + 1);
      pop = pop - 1;
      t   = t + ivl + 2;
    end
  endtask

  task automatic expect_evt(input int d, input int kind);
    evt_t e;
    tests++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      fails++;
      $display("FAIL dut%0d event: got %s@%0d, required none", d, kname(kind), cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.kind != kind || e.cyc != cyc) begin
      fails++;
      $display("FAIL dut%0d event: got %s@%0d, required %s@%0d",
               d, kname(kind), cyc, kname(e.kind), e.cyc);
    end
  endtask

  // Monitor: every pulse presented by a DUT must match the queue head.
  always @(negedge clk) begin
    if (load0 === 1'b1) expect_evt(0, K_LOAD);
    if (hl0   === 1'b1) expect_evt(0, K_HL);
    if (down0 === 1'b1) expect_evt(0, K_DOWN);
    if (done0 === 1'b1) expect_evt(0, K_DONE);
    if (load1 === 1'b1) expect_evt(1, K_LOAD);
    if (hl1   === 1'b1) expect_evt(1, K_HL);
    if (down1 === 1'b1) expect_evt(1, K_DOWN);
    if (done1 === 1'b1) expect_evt(1, K_DONE);
  end

  task automatic check_eq(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, " load0"}, int'(load0), 0);
    check_eq({tag, " down0"}, int'(down0), 0);
    check_eq({tag, " busy0"}, int'(busy0), 0);
    check_eq({tag, " hl0"},   int'(hl0),   0);
    check_eq({tag, " done0"}, int'(done0), 0);
    check_eq({tag, " lval0"}, int'(lval0), 0);
  endtask

  // Present start for one cycle and queue the expected schedule.
  task automatic start_run(input int d, input int init, input int per, output int base);
    base = cyc;
    $display("[TB] run dut%0d init_val=%0d period=%0d at cycle %0d", d, init, per, base);
    if (d == 0) begin
      start0 = 1'b1; init0 = 4'(init); per0 = 16'(per);
      push_model(0, init, per, 65535, base);
    end else begin
      start1 = 1'b1; init1 = 4'(init); per1 = 4'(per);
      push_model(1, init, per, 15, base);
    end
    step();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (d == 0) ok = (q0.size() == 0) && !busy0;
      else        ok = (q1.size() == 0) && !busy1;
      if (ok) break;
      step();
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL dut%0d drain: got %0d events pending or busy, required 0 within %0d cycles",
               d, (d == 0) ? q0.size() : q1.size(), budget);
    end
  endtask

  initial begin
    int base;
    int tstep;
    int ndown;
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; init0 = '0; per0 = '0;
    start1 = 1'b0; abort1 = 1'b0; init1 = '0; per1 = '0;
    repeat (3) step();
    check_quiet("reset");
    check_eq("reset busy1", int'(busy1), 0);
    rst = 1'b0;
    step();

    // Reference run 8/3, with a start pulse ignored mid-run.
    start_run(0, 8, 3, base);
    repeat (10) step();
    start0 = 1'b1; init0 = 4'd3; per0 = 16'd1;
    step();
    start0 = 1'b0;
    check_eq("load_val held", int'(lval0), 8);
    wait_idle(0, 500);

    // Empty population: load, check, done, no decrements.
    start_run(0, 0, 5, base);
    wait_idle(0, 100);

    // Zero period behaves as one.
    start_run(0, 2, 0, base);
    wait_idle(0, 200);

    // Interval saturation on the narrow instance.
    start_run(1, 15, 12, base);
    wait_idle(1, 1000);

    // Abort in the STEP cycle of the second decrement.
    start_run(0, 6, 2, base);
    tstep = 0;
    ndown = 0;
    for (int i = 0; i < q0.size(); i++) begin
      if (q0[i].kind == K_DOWN) begin
        ndown++;
        if (ndown == 2) tstep = q0[i].cyc;
      end
    end
    while (q0.size() > 0 && q0[$].cyc > tstep) void'(q0.pop_back());
    for (int i = 0; i < 200 && cyc < tstep; i++) step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    check_eq("abort busy0", int'(busy0), 0);
    wait_idle(0, 50);

    // Reset held two cycles during WAIT.
    start_run(0, 8, 3, base);
    for (int i = 0; i < 20 && cyc < base + 3; i++) step();
    rst = 1'b1;
    q0.delete();
    step();
    step();
    rst = 1'b0;
    step();
    check_quiet("mid-run reset");

    // Randomized runs on both instances.
    for (int r = 0; r < 10; r++) begin
      int d;
      int iv;
      int pv;
      d  = int'($urandom_range(0, 1));
      iv = int'($urandom_range(0, 15));
      pv = (d == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
      start_run(d, iv, pv, base);
      wait_idle(d, 3000);
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
